// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with load-use hazard detection
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_stall_i,
    input  logic              flush_i,
    input  logic [4:0]        ID_rs1_i,
    input  logic [4:0]        ID_rs2_i,
    input  logic [4:0]        ID_rd_i,
    input  logic [DATA_W-1:0] ID_rs1data_i,
    input  logic [DATA_W-1:0] ID_rs2data_i,
    input  logic [DATA_W-1:0] ID_imm_i,
    input  logic [9:0]        ID_funct_i,
    input  logic [6:0]        ID_ctrl_i,
    output logic              stall_o,
    output logic [4:0]        EX_rs1_o,
    output logic [4:0]        EX_rs2_o,
    output logic [4:0]        EX_rd_o,
    output logic [DATA_W-1:0] EX_rs1data_o,
    output logic [DATA_W-1:0] EX_rs2data_o,
    output logic [DATA_W-1:0] EX_imm_o,
    output logic [9:0]        EX_funct_o,
    output logic [6:0]        EX_ctrl_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    // Control packing: {RegWrite, MemtoReg, MemRead, MemWrite, ALUOp[1:0], ALUSrc}
    localparam int MEMREAD_BIT = 4;

    logic ex_mem_read;
    logic rd_nonzero;
    logic rd_matches;
    logic load_bubble;
    logic cnt_sat;

    assign ex_mem_read = EX_ctrl_o[MEMREAD_BIT];
    assign rd_nonzero  = (EX_rd_o != 5'd0);
    assign rd_matches  = (EX_rd_o == ID_rs1_i) || (EX_rd_o == ID_rs2_i);
    assign stall_o     = ex_mem_read && rd_nonzero && rd_matches;

    assign load_bubble = stall_o || flush_i;
    assign cnt_sat     = (bubble_cnt_o == {CNT_W{1'b1}});

    // Bubbles clear the register indices too so EX forwarding never matches them.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            EX_rs1_o     <= '0;
            EX_rs2_o     <= '0;
            EX_rd_o      <= '0;
            EX_rs1data_o <= '0;
            EX_rs2data_o <= '0;
            EX_imm_o     <= '0;
            EX_funct_o   <= '0;
            EX_ctrl_o    <= '0;
        end else if (mem_stall_i) begin
            EX_rs1_o     <= EX_rs1_o;
            EX_rs2_o     <= EX_rs2_o;
            EX_rd_o      <= EX_rd_o;
            EX_rs1data_o <= EX_rs1data_o;
            EX_rs2data_o <= EX_rs2data_o;
            EX_imm_o     <= EX_imm_o;
            EX_funct_o   <= EX_funct_o;
            EX_ctrl_o    <= EX_ctrl_o;
        end else if (load_bubble) begin
            EX_rs1_o     <= '0;
            EX_rs2_o     <= '0;
            EX_rd_o      <= '0;
            EX_rs1data_o <= '0;
            EX_rs2data_o <= '0;
            EX_imm_o     <= '0;
            EX_funct_o   <= '0;
            EX_ctrl_o    <= '0;
        end else begin
            EX_rs1_o     <= ID_rs1_i;
            EX_rs2_o     <= ID_rs2_i;
            EX_rd_o      <= ID_rd_i;
            EX_rs1data_o <= ID_rs1data_i;
            EX_rs2data_o <= ID_rs2data_i;
            EX_imm_o     <= ID_imm_i;
            EX_funct_o   <= ID_funct_i;
            EX_ctrl_o    <= ID_ctrl_i;
        end
    end

    // Only load-use bubbles are counted; flush-only bubbles are not.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bubble_cnt_o <= '0;
        end else if (!mem_stall_i && stall_o && !cnt_sat) begin
            bubble_cnt_o <= bubble_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - directed-vector bench for id_ex_stage_reg
module tb_id_ex_stage_reg;

    localparam int DATA_W  = 32;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [6:0] CTRL_LW  = 7'b1110001;
    localparam logic [6:0] CTRL_ADD = 7'b1000000;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              mem_stall_i;
    logic              flush_i;
    logic [4:0]        ID_rs1_i, ID_rs2_i, ID_rd_i;
    logic [DATA_W-1:0] ID_rs1data_i, ID_rs2data_i, ID_imm_i;
    logic [9:0]        ID_funct_i;
    logic [6:0]        ID_ctrl_i;
    logic              stall_o;
    logic [4:0]        EX_rs1_o, EX_rs2_o, EX_rd_o;
    logic [DATA_W-1:0] EX_rs1data_o, EX_rs2data_o, EX_imm_o;
    logic [9:0]        EX_funct_o;
    logic [6:0]        EX_ctrl_o;
    logic [CNT_W-1:0]  bubble_cnt_o;

    int n_vec = 0;
    int n_bad = 0;

    id_ex_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .mem_stall_i  (mem_stall_i),
        .flush_i      (flush_i),
        .ID_rs1_i     (ID_rs1_i),
        .ID_rs2_i     (ID_rs2_i),
        .ID_rd_i      (ID_rd_i),
        .ID_rs1data_i (ID_rs1data_i),
        .ID_rs2data_i (ID_rs2data_i),
        .ID_imm_i     (ID_imm_i),
        .ID_funct_i   (ID_funct_i),
        .ID_ctrl_i    (ID_ctrl_i),
        .stall_o      (stall_o),
        .EX_rs1_o     (EX_rs1_o),
        .EX_rs2_o     (EX_rs2_o),
        .EX_rd_o      (EX_rd_o),
        .EX_rs1data_o (EX_rs1data_o),
        .EX_rs2data_o (EX_rs2data_o),
        .EX_imm_o     (EX_imm_o),
        .EX_funct_o   (EX_funct_o),
        .EX_ctrl_o    (EX_ctrl_o),
        .bubble_cnt_o (bubble_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [6:0] ctrl, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [9:0] funct);
        ID_rs1_i     = rs1;
        ID_rs2_i     = rs2;
        ID_rd_i      = rd;
        ID_ctrl_i    = ctrl;
        ID_rs1data_i = d1;
        ID_rs2data_i = d2;
        ID_imm_i     = imm;
        ID_funct_i   = funct;
    endtask

    initial begin
        rst_i       = 1'b0;
        mem_stall_i = 1'b0;
        flush_i     = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);

        // 1: reset then pass-through
        step();
        step();
        check("rst_rd",    EX_rd_o, 0);
        check("rst_ctrl",  EX_ctrl_o, 0);
        check("rst_data",  EX_rs1data_o, 0);
        check("rst_cnt",   bubble_cnt_o, 0);
        check("rst_stall", stall_o, 0);
        rst_i = 1'b1;
        set_id(0, 0, 7, 7'b1000001, 32'h1234, 0, 32'h10, 10'h005);
        step();
        check("pt_rd",    EX_rd_o, 7);
        check("pt_data",  EX_rs1data_o, 32'h1234);
        check("pt_ctrl",  EX_ctrl_o, 7'b1000001);
        check("pt_imm",   EX_imm_o, 32'h10);
        check("pt_funct", EX_funct_o, 10'h005);
        check("pt_stall", stall_o, 0);

        // 2: load-use on rs2
        set_id(2, 0, 5, CTRL_LW, 32'h100, 0, 32'h4, 10'h002);
        step();
        set_id(3, 5, 6, CTRL_ADD, 32'hAA, 32'hBB, 0, 10'h000);
        #1;
        check("lu_stall", stall_o, 1);
        step();
        check("lu_b_ctrl",  EX_ctrl_o, 0);
        check("lu_b_rd",    EX_rd_o, 0);
        check("lu_b_rs2",   EX_rs2_o, 0);
        check("lu_b_data",  EX_rs1data_o, 0);
        check("lu_b_stall", stall_o, 0);
        check("lu_b_cnt",   bubble_cnt_o, 1);
        step();
        check("lu_cap_rd",   EX_rd_o, 6);
        check("lu_cap_rs2",  EX_rs2_o, 5);
        check("lu_cap_d2",   EX_rs2data_o, 32'hBB);
        check("lu_cap_ctrl", EX_ctrl_o, CTRL_ADD);
        check("lu_cap_cnt",  bubble_cnt_o, 1);

        // 3: load to x0 never stalls
        set_id(1, 0, 0, CTRL_LW, 0, 0, 0, 0);
        step();
        set_id(0, 0, 8, CTRL_ADD, 32'h55, 0, 0, 0);
        #1;
        check("x0_stall", stall_o, 0);
        step();
        check("x0_rd",   EX_rd_o, 8);
        check("x0_data", EX_rs1data_o, 32'h55);
        check("x0_cnt",  bubble_cnt_o, 1);

        // 4: memory stall overlapping load-use
        set_id(1, 0, 4, CTRL_LW, 0, 0, 0, 0);
        step();
        set_id(4, 0, 10, CTRL_ADD, 32'h77, 0, 0, 0);
        mem_stall_i = 1'b1;
        #1;
        check("ms_stall0", stall_o, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("ms_rd",    EX_rd_o, 4);
            check("ms_ctrl",  EX_ctrl_o, CTRL_LW);
            check("ms_cnt",   bubble_cnt_o, 1);
            check("ms_stall", stall_o, 1);
        end
        mem_stall_i = 1'b0;
        step();
        check("ms_b_ctrl", EX_ctrl_o, 0);
        check("ms_b_cnt",  bubble_cnt_o, 2);
        step();
        check("ms_cap_rd", EX_rd_o, 10);

        // 5: flush alone, then flush with load-use
        set_id(0, 0, 9, CTRL_ADD, 32'h99, 0, 0, 0);
        flush_i = 1'b1;
        step();
        check("fl_ctrl", EX_ctrl_o, 0);
        check("fl_rd",   EX_rd_o, 0);
        check("fl_cnt",  bubble_cnt_o, 2);
        flush_i = 1'b0;
        set_id(1, 0, 11, CTRL_LW, 0, 0, 0, 0);
        step();
        set_id(11, 0, 12, CTRL_ADD, 0, 0, 0, 0);
        flush_i = 1'b1;
        #1;
        check("fllu_stall", stall_o, 1);
        step();
        check("fllu_ctrl", EX_ctrl_o, 0);
        check("fllu_cnt",  bubble_cnt_o, 3);
        flush_i = 1'b0;
        step();
        check("fllu_cap_rd", EX_rd_o, 12);

        // 6: saturation, then asynchronous reset between edges
        for (int i = 3; i < CNT_MAX; i++) begin
            set_id(0, 0, 13, CTRL_LW, 0, 0, 0, 0);
            step();
            set_id(13, 0, 14, CTRL_ADD, 0, 0, 0, 0);
            step();
        end
        check("sat_full", bubble_cnt_o, CNT_MAX);
        set_id(0, 0, 13, CTRL_LW, 0, 0, 0, 0);
        step();
        set_id(0, 13, 14, CTRL_ADD, 0, 0, 0, 0);
        #1;
        check("sat_stall", stall_o, 1);
        step();
        check("sat_hold", bubble_cnt_o, CNT_MAX);
        check("sat_ctrl", EX_ctrl_o, 0);
        set_id(0, 0, 13, CTRL_LW, 32'hDEAD, 0, 0, 0);
        step();
        set_id(13, 0, 14, CTRL_ADD, 0, 0, 0, 0);
        #1;
        check("ar_pre_stall", stall_o, 1);
        #1;
        rst_i = 1'b0;
        #1;
        check("ar_rd",    EX_rd_o, 0);
        check("ar_ctrl",  EX_ctrl_o, 0);
        check("ar_data",  EX_rs1data_o, 0);
        check("ar_cnt",   bubble_cnt_o, 0);
        check("ar_stall", stall_o, 0);
        step();
        rst_i = 1'b1;
        set_id(0, 0, 15, CTRL_ADD, 32'h4321, 0, 0, 0);
        step();
        check("post_rd",   EX_rd_o, 15);
        check("post_data", EX_rs1data_o, 32'h4321);
        check("post_cnt",  bubble_cnt_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
